// File: rtl/note_judge_pkg.sv
// Shared types and constants for the note judgement block.
package note_judge_pkg;

    // Target times are kept one bit wider than the game timer so that
    // spawn time + travel time can never wrap.
    localparam int unsigned TIME_W     = 33;
    localparam int unsigned JUDGE_W    = 2;
    localparam int unsigned NUM_TRACKS = 2;

    // Judgement codes as seen on o_judge1 / o_judge2.
    localparam logic [JUDGE_W-1:0] JUDGE_NONE    = 2'd0;
    localparam logic [JUDGE_W-1:0] JUDGE_PERFECT = 2'd1;
    localparam logic [JUDGE_W-1:0] JUDGE_GOOD    = 2'd2;
    localparam logic [JUDGE_W-1:0] JUDGE_MISS    = 2'd3;

    // Track encoding shared with the chart sequencer.
    typedef enum logic [1:0] {
        TRACK_NONE  = 2'd0,
        TRACK_UPPER = 2'd1,
        TRACK_LOWER = 2'd2,
        TRACK_BOTH  = 2'd3
    } track_e;

    // Absolute distance between two target-width times.
    function automatic logic [TIME_W-1:0] abs_diff(
        input logic [TIME_W-1:0] a,
        input logic [TIME_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/note_lane_queue.sv
// Per-track FIFO of note target times; accepts a push while full if the head pops.
module note_lane_queue
    import note_judge_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = TIME_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/note_judge.sv
// Timestamps spawned notes, judges hits against arrival time, keeps score/combo.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned TRAVEL_MS   = 1000,
    parameter int unsigned PERFECT_MS  = 50,
    parameter int unsigned GOOD_MS     = 150,
    parameter int unsigned QDEPTH      = 8,
    parameter int unsigned PERFECT_PTS = 100,
    parameter int unsigned GOOD_PTS    = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_cur_time,
    input  logic        i_note_t1,
    input  logic        i_note_t2,
    input  logic        i_game_end,
    input  logic        i_hit_t1,
    input  logic        i_hit_t2,
    output logic        o_judge1_valid,
    output logic [1:0]  o_judge1,
    output logic        o_judge2_valid,
    output logic [1:0]  o_judge2,
    output logic [31:0] o_score,
    output logic [15:0] o_combo,
    output logic [15:0] o_max_combo,
    output logic        o_overflow,
    output logic        o_done
);

    localparam int unsigned SCORE_W = 32;
    localparam int unsigned COMBO_W = 16;

    // Index 0 is track 1 (upper), index 1 is track 2 (lower).
    logic [NUM_TRACKS-1:0] w_spawn;
    logic [NUM_TRACKS-1:0] w_hit;
    logic [NUM_TRACKS-1:0] w_full;
    logic [NUM_TRACKS-1:0] w_empty;
    logic [NUM_TRACKS-1:0] w_push;
    logic [NUM_TRACKS-1:0] w_pop;
    logic [NUM_TRACKS-1:0] w_drop;
    logic [NUM_TRACKS-1:0] w_expired;
    logic [NUM_TRACKS-1:0] w_jv;
    logic [TIME_W-1:0]     w_head [NUM_TRACKS];
    logic [TIME_W-1:0]     w_dist [NUM_TRACKS];
    logic [JUDGE_W-1:0]    w_code [NUM_TRACKS];

    logic [TIME_W-1:0]     w_now;
    logic [TIME_W-1:0]     w_target;

    logic [SCORE_W+1:0]    w_pts_sum;
    logic [SCORE_W+1:0]    w_score_sum;
    logic [SCORE_W-1:0]    w_score_next;
    logic [1:0]            w_n_hit;
    logic                  w_any_miss;
    logic [COMBO_W:0]      w_combo_sum;
    logic [COMBO_W-1:0]    w_combo_next;
    logic [COMBO_W-1:0]    w_max_next;
    logic                  w_done_set;

    logic [NUM_TRACKS-1:0] r_judge_valid;
    logic [JUDGE_W-1:0]    r_judge [NUM_TRACKS];
    logic [SCORE_W-1:0]    r_score;
    logic [COMBO_W-1:0]    r_combo;
    logic [COMBO_W-1:0]    r_max_combo;
    logic                  r_overflow;
    logic                  r_done;

    assign w_spawn  = {i_note_t2, i_note_t1};
    assign w_hit    = {i_hit_t2, i_hit_t1};
    assign w_now    = {1'b0, i_cur_time};
    assign w_target = w_now + TIME_W'(TRAVEL_MS);

    for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_lane
        note_lane_queue #(
            .DEPTH (QDEPTH),
            .WIDTH (TIME_W)
        ) u_queue (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (w_target),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );

        assign w_expired[g] = !w_empty[g] && (w_now > (w_head[g] + TIME_W'(GOOD_MS)));
        assign w_dist[g]    = abs_diff(w_now, w_head[g]);
    end

    // Per-track judgement and push/drop decision; expiry outranks any hit.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        w_jv   = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            w_code[i] = JUDGE_NONE;
        end
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (w_expired[i]) begin
                w_pop[i]  = 1'b1;
                w_jv[i]   = 1'b1;
                w_code[i] = JUDGE_MISS;
            end else if (!w_empty[i] && w_hit[i] && (w_dist[i] <= TIME_W'(PERFECT_MS))) begin
                w_pop[i]  = 1'b1;
                w_jv[i]   = 1'b1;
                w_code[i] = JUDGE_PERFECT;
            end else if (!w_empty[i] && w_hit[i] && (w_dist[i] <= TIME_W'(GOOD_MS))) begin
                w_pop[i]  = 1'b1;
                w_jv[i]   = 1'b1;
                w_code[i] = JUDGE_GOOD;
            end
            w_push[i] = w_spawn[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = w_spawn[i] && w_full[i] && !w_pop[i];
        end
    end

    // Score and combo next-state from this cycle's judgements.
    always_comb begin
        w_pts_sum  = '0;
        w_n_hit    = '0;
        w_any_miss = 1'b0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (w_code[i] == JUDGE_PERFECT) begin
                w_pts_sum = w_pts_sum + (SCORE_W+2)'(PERFECT_PTS);
                w_n_hit   = w_n_hit + 2'd1;
            end else if (w_code[i] == JUDGE_GOOD) begin
                w_pts_sum = w_pts_sum + (SCORE_W+2)'(GOOD_PTS);
                w_n_hit   = w_n_hit + 2'd1;
            end else if (w_code[i] == JUDGE_MISS) begin
                w_any_miss = 1'b1;
            end
        end

        w_score_sum  = {2'b00, r_score} + w_pts_sum;
        w_score_next = (w_score_sum > (SCORE_W+2)'({SCORE_W{1'b1}})) ?
                       {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

        w_combo_sum  = {1'b0, r_combo} + (COMBO_W+1)'(w_n_hit);
        if (w_any_miss) begin
            w_combo_next = '0;
        end else if (w_combo_sum > (COMBO_W+1)'({COMBO_W{1'b1}})) begin
            w_combo_next = {COMBO_W{1'b1}};
        end else begin
            w_combo_next = w_combo_sum[COMBO_W-1:0];
        end

        w_max_next = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
    end

    assign w_done_set = i_game_end && (&w_empty) && !(|w_spawn);

    // Registered judgement strobes, score, combo and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_judge_valid <= '0;
            for (int i = 0; i < NUM_TRACKS; i++) begin
                r_judge[i] <= JUDGE_NONE;
            end
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_judge_valid <= w_jv;
            for (int i = 0; i < NUM_TRACKS; i++) begin
                if (w_jv[i]) begin
                    r_judge[i] <= w_code[i];
                end
            end
            r_score     <= w_score_next;
            r_combo     <= w_combo_next;
            r_max_combo <= w_max_next;
            r_overflow  <= r_overflow | (|w_drop);
            r_done      <= r_done | w_done_set;
        end
    end

    assign o_judge1_valid = r_judge_valid[0];
    assign o_judge1       = r_judge[0];
    assign o_judge2_valid = r_judge_valid[1];
    assign o_judge2       = r_judge[1];
    assign o_score        = r_score;
    assign o_combo        = r_combo;
    assign o_max_combo    = r_max_combo;
    assign o_overflow     = r_overflow;
    assign o_done         = r_done;

endmodule
